imem_loader: RTL

- Byte-serial program loader; the write side of the CPU's 32-word instruction store, which the CPU core itself only reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the assembled words into the instruction store via a single-word write port.
- Holds the CPU in reset until a complete, checksum-verified image has landed.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_loader_word_asm.sv | 26 ++
 rtl/imem_loader.sv | 96 +++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and sizing.
// Used by the loader and by the instruction store it fills.
package imem_loader_pkg;

    localparam int LOADER_DEPTH  = 32;
    localparam int LOADER_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        CHECK   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and store write port of the loader.
// master = byte source / store side, slave = loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: drops each byte into its lane
// and pulses word_valid the cycle after lane 3 lands.
module imem_loader_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    input  logic [1:0]  lane,
    output logic [31:0] word,
    output logic        word_valid
);

    // Lane write and one-cycle completion strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= accept && (lane == 2'd3);
            if (accept) begin
                word[{lane, 3'b000} +: 8] <= byte_in;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-serial loader for the instruction store.
// Keeps the CPU in reset until a checksum-verified image lands.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = LOADER_DEPTH,
    parameter int ADDR_W = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    loader_state_t state;
    logic [1:0]    lane;
    logic [ADDR_W:0] count;
    logic [7:0]    csum;
    logic          accept;
    logic          asm_accept;
    logic          bad_count;
    logic          last_word;
    logic          word_valid;
    logic [31:0]   word;

    assign bus.in_ready = (state == IDLE) ||
                          (state == PAYLOAD) ||
                          (state == CHECK);
    assign accept     = bus.in_valid && bus.in_ready;
    assign asm_accept = accept && (state == PAYLOAD);
    assign bad_count  = (bus.in_data == 8'd0) ||
                        (32'(bus.in_data) > 32'(DEPTH));
    assign last_word  = (words_loaded == count - 1'b1);

    assign bus.wr_en   = word_valid;
    assign bus.wr_data = word;
    assign cpu_reset   = (state != DONE);
    assign done        = (state == DONE);
    assign error       = (state == ERROR);

    imem_loader_word_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (bus.in_data),
        .accept     (asm_accept),
        .lane       (lane),
        .word       (word),
        .word_valid (word_valid)
    );

    // Frame FSM, checksum, lane and word-address tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lane         <= 2'd0;
            count        <= '0;
            csum         <= 8'd0;
            words_loaded <= '0;
            bus.wr_addr  <= '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (bad_count) begin
                        state <= ERROR;
                    end else begin
                        count <= bus.in_data[ADDR_W:0];
                        csum  <= 8'd0;
                        lane  <= 2'd0;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    csum <= csum ^ bus.in_data;
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        bus.wr_addr  <= words_loaded[ADDR_W-1:0];
                        words_loaded <= words_loaded + 1'b1;
                        if (last_word) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    state <= (bus.in_data == csum) ? DONE : ERROR;
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
